// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch redirect flushes, memory-busy freeze, watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_controller #(
    parameter int unsigned EXTRA_FLUSH = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_read_mem_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_bnj_taken_i,
    input  logic        mem_busy_i,
    output logic        if_stall_o,
    output logic        if_flush_o,
    output logic        id_stall_o,
    output logic        id_flush_o,
    output logic        ex_stall_o,
    output logic        mem_stall_o,
    output logic        pc_sel_o,
    output logic        mem_timeout_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StRedirect = 2'd1;
    localparam logic [1:0] StMemWait  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q, ret_d;
    logic [1:0] eff_state;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;
    logic       timeout_q, timeout_d;
    logic       lu_hazard;

    assign lu_hazard = ex_read_mem_i & (ex_rd_i != 5'd0) &
                       ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

    always_comb begin
        if_stall_o  = 1'b0;
        if_flush_o  = 1'b0;
        id_stall_o  = 1'b0;
        id_flush_o  = 1'b0;
        ex_stall_o  = 1'b0;
        mem_stall_o = 1'b0;
        pc_sel_o    = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        // Leaving MEM_WAIT behaves exactly like the saved state in the same cycle.
        eff_state   = (state_q == StMemWait) ? ret_q : state_q;

        if (reset) begin
            state_d = StRun;
        end else if (mem_busy_i) begin
            if_stall_o  = 1'b1;
            id_stall_o  = 1'b1;
            ex_stall_o  = 1'b1;
            mem_stall_o = 1'b1;
            state_d     = StMemWait;
            ret_d       = eff_state;
        end else begin
            case (eff_state)
                StRedirect: begin
                    if_flush_o = 1'b1;
                    cnt_d      = cnt_q - 3'd1;
                    state_d    = (cnt_q == 3'd1) ? StRun : StRedirect;
                end
                default: begin
                    state_d = StRun;
                    if (ex_bnj_taken_i) begin
                        pc_sel_o   = 1'b1;
                        if_flush_o = 1'b1;
                        id_flush_o = 1'b1;
                        cnt_d      = 3'(EXTRA_FLUSH);
                        state_d    = (EXTRA_FLUSH != 0) ? StRedirect : StRun;
                    end else if (lu_hazard) begin
                        if_stall_o = 1'b1;
                        id_flush_o = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        if (!mem_busy_i) begin
            busy_cnt_d = 8'd0;
        end else if (busy_cnt_q == 8'hff) begin
            busy_cnt_d = busy_cnt_q;
        end else begin
            busy_cnt_d = busy_cnt_q + 8'd1;
        end
        timeout_d = timeout_q | (32'(busy_cnt_d) >= MEM_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            ret_q      <= StRun;
            cnt_q      <= 3'd0;
            busy_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            busy_cnt_q <= busy_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign state_o       = state_q;
    assign mem_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // An if_stall without mem_busy_i can only be a load-use bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(if_stall_o);
            flush_cnt_q <= flush_cnt_q + 32'(pc_sel_o | (if_stall_o & ~mem_busy_i));
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_events_o = 32'd0;
`endif

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock and one reset, with reset synchronous and active-high; this is decided, not open.
REQ-002 SHALL have parameter EXTRA_FLUSH, default 1: IF/ID kill cycles after a redirect, beyond the resolve cycle; legal range 0..7.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15: consecutive mem_busy_i cycles before the watchdog trips; legal range 1..255.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ex_read_mem_i  in  1  EX holds a load.
- ex_rd_i  in  5  EX destination register.
- id_rs1_i  in  5  ID source 1 address.
- id_rs2_i  in  5  ID source 2 address.
- id_uses_rs2_i  in  1  ID instruction reads rs2.
- ex_bnj_taken_i  in  1  EX branch/jump resolved taken.
- mem_busy_i  in  1  data memory not ready.
- if_stall_o  out  1  hold PC and IF/ID.
- if_flush_o  out  1  zero IF/ID.
- id_stall_o  out  1  hold ID/EX.
- id_flush_o  out  1  zero ID/EX; flush beats stall downstream.
- ex_stall_o  out  1  hold EX/MEM.
- mem_stall_o  out  1  hold MEM/WB.
- pc_sel_o  out  1  PC takes branch target this cycle.
- mem_timeout_o  out  1  sticky watchdog flag.
- state_o  out  2  FSM state, for debug.
- stall_cycles_o  out  32  performance counter.
- flush_events_o  out  32  performance counter.

Function
REQ-005 SHALL implement FSM states RUN=0, REDIRECT=1, MEM_WAIT=2, with state_o equal to the current state.
REQ-006 SHALL define lu_hazard = ex_read_mem_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs1_i) | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
REQ-007 SHALL apply fixed priority within a cycle: mem_busy_i > ex_bnj_taken_i > lu_hazard.
REQ-008 SHALL drive all outputs combinationally from the current state and inputs, with zero-cycle latency; every output not named in a rule SHALL be 0.
REQ-009 SHALL, whenever mem_busy_i=1 in any state, assert if_stall_o, id_stall_o, ex_stall_o and mem_stall_o; drive no flush and no pc_sel_o; enter MEM_WAIT; and save the return state (RUN, or REDIRECT with its remaining count).
REQ-010 SHALL, in MEM_WAIT with mem_busy_i=0, drive no stall, resume the saved state's output rules in that same cycle, and update the state per those rules.
REQ-011 SHALL, in RUN with ex_bnj_taken_i=1 and mem_busy_i=0, assert pc_sel_o, if_flush_o and id_flush_o for one cycle, load the redirect counter with EXTRA_FLUSH, and go to REDIRECT if EXTRA_FLUSH>0, else stay in RUN.
REQ-012 SHALL, in REDIRECT, assert if_flush_o each non-busy cycle, decrement the counter, and return to RUN when it reaches 0; a busy cycle SHALL freeze the counter.
REQ-013 SHALL ignore ex_bnj_taken_i and lu_hazard in REDIRECT, because EX and ID hold bubbles there.
REQ-014 SHALL, in RUN with lu_hazard=1 and no higher-priority event, assert if_stall_o and id_flush_o for exactly that cycle (one bubble) and stay in RUN.
REQ-015 SHALL not respond to a branch whose EX stage is frozen by mem_busy_i until the first non-busy cycle; because EX is frozen, ex_bnj_taken_i stays valid into that cycle.
REQ-016 SHALL count consecutive mem_busy_i=1 cycles in an 8-bit saturating counter that clears on any mem_busy_i=0 cycle.
REQ-017 SHALL set mem_timeout_o on the cycle after that count reaches MEM_TIMEOUT, and hold it until reset.

Reset
REQ-018 SHALL, when reset=1 at a clock edge, put the FSM in RUN and clear the redirect counter, busy counter, mem_timeout_o and both performance counters; this applies mid-REDIRECT and mid-MEM_WAIT too.
REQ-019 SHALL drive every combinational output to 0 while reset=1, regardless of the other inputs.

Configuration
REQ-020 SHALL, when HAZARD_PERF_CNT_EN is defined, increment stall_cycles_o each cycle if_stall_o=1 and increment flush_events_o each cycle pc_sel_o=1 or an lu_hazard bubble is inserted; both counters SHALL wrap modulo 2^32.
REQ-021 SHALL, when HAZARD_PERF_CNT_EN is undefined, keep both ports present and tied to 0, with no counter flops.

Verification
REQ-022 SHALL cover load-use: ex_read_mem_i=1, ex_rd_i=5, id_rs1_i=5 -> if_stall_o=1 and id_flush_o=1 for one cycle; with ex_rd_i=0 -> no stall.
REQ-023 SHALL cover rs2 masking: ex_rd_i=7, id_rs2_i=7, id_uses_rs2_i=0 -> no stall; with id_uses_rs2_i=1 -> stall.
REQ-024 SHALL cover redirect with EXTRA_FLUSH=2: a taken pulse in RUN -> cycle T shows pc_sel_o, if_flush_o and id_flush_o; T+1 and T+2 show if_flush_o only; RUN at T+3.
REQ-025 SHALL cover the branch/busy collision: ex_bnj_taken_i and mem_busy_i both 1 for 3 cycles -> full stall, no pc_sel_o; the cycle mem_busy_i drops -> pc_sel_o=1.
REQ-026 SHALL cover the watchdog with MEM_TIMEOUT=4: mem_busy_i high 4 cycles -> mem_timeout_o=1 on the next cycle and it stays 1 after busy drops; a reset pulse -> 0.
REQ-027 SHALL cover reset during REDIRECT: state_o returns to 0 and all outputs are 0; with HAZARD_PERF_CNT_EN defined, both counters read 0.
